traffic_light_multi: RTL
========================

# traffic_light_multi

Parametrised N-direction traffic-light controller, successor to the fixed two-direction, four-state controller/decoder pair. It serves N_DIR approaches in round-robin order with programmable green, yellow and all-red durations. It skips approaches with no vehicle demand, rests in green when only the active approach has demand, and supports a flashing-yellow maintenance mode. It sits at the top of the intersection datapath and drives the lamp drivers directly.

## Interface
- N_DIR, 4: number of approaches, ≥ 2
- TICK_DIV, 1000: clk cycles per timing tick, ≥ 1
- GREEN_TICKS, 20: green duration in ticks, ≥ 1
- YELLOW_TICKS, 3: yellow duration in ticks, ≥ 1
- ALL_RED_TICKS, 1: all-red clearance in ticks, ≥ 1
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req  input  N_DIR  per-approach demand, level-sensitive, sampled only on tick cycles
- flash  input  1  maintenance request, level-sensitive, sampled every cycle
- red  output  N_DIR  red lamp per approach
- yellow  output  N_DIR  yellow lamp per approach
- green  output  N_DIR  green lamp per approach
- phase  output  $clog2(N_DIR)  index of current or last-served approach
- state  output  2  FSM state: GREEN=0, YELLOW=1, ALL_RED=2, FLASH=3

## Operation
- Prescaler `presc` counts from 0 to TICK_DIV-1. `tick` = (presc == TICK_DIV-1). `presc` clears on every state change and on rst, so each state lasts exactly its tick count times TICK_DIV cycles.
- On entering a timed state, `timer` loads DUR-1. On each tick, if `timer` > 0 it decrements; if `timer` == 0 the transition is evaluated.
- GREEN → YELLOW on expiry when req == 0 (fixed-time rotation) or when any req bit other than req[phase] is set.
- GREEN rests on expiry when req is nonzero and only req[phase] is set. `timer` stays 0 and the condition is re-evaluated every tick.
- YELLOW → ALL_RED on expiry.
- ALL_RED → GREEN on expiry, with `phase` set to the next approach:
  - req == 0: next = (phase+1) mod N_DIR.
  - Otherwise: first set req bit searching phase+1, phase+2, … with wrap-around, checking phase itself last.
- FLASH entry: flash == 1 in any non-FLASH state → FLASH on the next cycle. This has priority over a simultaneous tick transition. `flash_ph` is set to 1 on entry and toggles every tick.
- FLASH exit: flash == 0 while in FLASH → ALL_RED on the next cycle, `timer` = ALL_RED_TICKS-1, `phase` unchanged.
- Lamp decode is combinational from registered state and `phase`:
  - GREEN: green = onehot(phase), red = ~onehot(phase).
  - YELLOW: yellow = onehot(phase), red = ~onehot(phase).
  - ALL_RED: red = all ones.
  - FLASH: yellow = {N_DIR{flash_ph}}, red = green = 0.
- Invariants:
  - At most one green bit is set.
  - Per approach, exactly one of red/yellow/green is set, except in FLASH.
  - Green is never followed directly by green of another approach.

## Timing
- Reset values: state=ALL_RED, phase=N_DIR-1, timer=ALL_RED_TICKS-1, presc=0, flash_ph=0.
- Lamps at reset: red = all ones, yellow = 0, green = 0.
- First green (approach 0 when req == 0) is asserted ALL_RED_TICKS*TICK_DIV cycles after rst deasserts.
- Full cycle per served approach with no rest: (GREEN_TICKS+YELLOW_TICKS+ALL_RED_TICKS)*TICK_DIV cycles.
- Outputs change on the clock edge after the deciding tick cycle, with no extra pipeline stage.
- rst mid-operation, including mid-FLASH: returns to the reset state on the next edge.
- req changes between ticks have no effect.

## Structure
- Package `traffic_pkg` holds:
  - the state enum (GREEN/YELLOW/ALL_RED/FLASH, 2-bit encoding as above);
  - a function for the timer width `$clog2(max duration)`.
- Sub-module `tl_dir_select`: combinational round-robin next-approach search. Inputs are req and phase; output is next_phase. Parametrised by N_DIR.
- Prescaler, timer and FSM live in the top module.

## Test plan
Config for all scenarios: N_DIR=4, TICK_DIV=2, GREEN=4, YELLOW=2, ALL_RED=1.
- Reset, req=0 → ALL_RED for 2 cycles, then green=0001 for 8 cycles, yellow=0001 for 4, red=1111 for 2, then green=0010. Rotation runs 0→1→2→3→0.
- req=0100 held from reset → first green=0100. Rests in green indefinitely with no yellow. Dropping req to 0 → yellow=0100 on the next tick boundary.
- req=1010 during green of approach 0 → serve order 1, 3, 1, 3; approaches 0 and 2 never green.
- flash pulse held 6 cycles mid-green → next cycle yellow=1111, red=green=0, toggling every 2 cycles. After release → red=1111 for 2 cycles, then green of next approach per req.
- rst asserted mid-yellow of approach 2 → next cycle red=1111, phase=3, state=2. Green=0001 follows 2 cycles after release.
- Random req/flash for 10⁵ cycles → invariants asserted every cycle: ≤1 green bit, one lamp per approach outside FLASH, no green-to-green change.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and sizing helpers for the multi-approach traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2,
    FLASH   = 2'd3
  } tl_state_e;

  // Width needed to hold (longest duration - 1); never narrower than one bit.
  function automatic int timer_width(input int g, input int y, input int a);
    int m;
    m = g;
    if (y > m) m = y;
    if (a > m) m = a;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/tl_dir_select.sv
// Round-robin search for the next approach to serve, starting after the current one.
module tl_dir_select #(
  parameter int N_DIR = 4,
  localparam int PW = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic [N_DIR-1:0] req,
  input  logic [PW-1:0]    phase,
  output logic [PW-1:0]    next_phase
);

  int  idx;
  logic found;

  // With no demand this falls back to plain rotation; the current approach is tried last.
  always_comb begin
    next_phase = PW'((int'(phase) + 1) % N_DIR);
    found      = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N_DIR; k++) begin
      idx = (int'(phase) + k) % N_DIR;
      if (!found && req[PW'(idx)]) begin
        next_phase = PW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_multi.sv
// N-approach round-robin traffic-light controller with demand skipping, green rest
// and flashing-yellow maintenance mode; lamps decode directly from registered state.
module traffic_light_multi
  import traffic_pkg::*;
#(
  parameter int N_DIR         = 4,
  parameter int TICK_DIV      = 1000,
  parameter int GREEN_TICKS   = 20,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DIR-1:0]         req,
  input  logic                     flash,
  output logic [N_DIR-1:0]         red,
  output logic [N_DIR-1:0]         yellow,
  output logic [N_DIR-1:0]         green,
  output logic [$clog2(N_DIR)-1:0] phase,
  output logic [1:0]               state
);

  localparam int PW = (N_DIR > 1) ? $clog2(N_DIR) : 1;
  localparam int TW = timer_width(GREEN_TICKS, YELLOW_TICKS, ALL_RED_TICKS);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  tl_state_e      state_q, state_n;
  logic [PW-1:0]  phase_q, phase_n;
  logic [TW-1:0]  timer_q, timer_n;
  logic [CW-1:0]  presc_q, presc_n;
  logic           flash_ph_q, flash_ph_n;
  logic           tick;
  logic [N_DIR-1:0] oh;
  logic [PW-1:0]  next_phase;

  assign tick = (presc_q == CW'(TICK_DIV - 1));
  assign oh   = {{(N_DIR-1){1'b0}}, 1'b1} << phase_q;

  tl_dir_select #(.N_DIR(N_DIR)) u_dir_select (
    .req        (req),
    .phase      (phase_q),
    .next_phase (next_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALL_RED;
      phase_q    <= PW'(N_DIR - 1);
      timer_q    <= TW'(ALL_RED_TICKS - 1);
      presc_q    <= '0;
      flash_ph_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      phase_q    <= phase_n;
      timer_q    <= timer_n;
      presc_q    <= presc_n;
      flash_ph_q <= flash_ph_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    phase_n    = phase_q;
    timer_n    = timer_q;
    flash_ph_n = flash_ph_q;
    // Maintenance entry wins over any tick-driven transition in the same cycle.
    if (state_q != FLASH && flash) begin
      state_n    = FLASH;
      flash_ph_n = 1'b1;
    end else if (state_q == FLASH) begin
      if (!flash) begin
        state_n = ALL_RED;
        timer_n = TW'(ALL_RED_TICKS - 1);
      end else if (tick) begin
        flash_ph_n = ~flash_ph_q;
      end
    end else if (tick) begin
      if (timer_q != '0) begin
        timer_n = timer_q - TW'(1);
      end else begin
        case (state_q)
          GREEN: begin
            // Rest in green while the active approach is the only one asking.
            if (req == '0 || (req & ~oh) != '0) begin
              state_n = YELLOW;
              timer_n = TW'(YELLOW_TICKS - 1);
            end
          end
          YELLOW: begin
            state_n = ALL_RED;
            timer_n = TW'(ALL_RED_TICKS - 1);
          end
          ALL_RED: begin
            state_n = GREEN;
            phase_n = next_phase;
            timer_n = TW'(GREEN_TICKS - 1);
          end
          default: ;
        endcase
      end
    end
    presc_n = (state_n != state_q || tick) ? '0 : presc_q + CW'(1);
  end

  always_comb begin
    red    = '0;
    yellow = '0;
    green  = '0;
    case (state_q)
      GREEN: begin
        green = oh;
        red   = ~oh;
      end
      YELLOW: begin
        yellow = oh;
        red    = ~oh;
      end
      ALL_RED: red = '1;
      FLASH:   yellow = {N_DIR{flash_ph_q}};
      default: ;
    endcase
  end

  assign phase = phase_q;
  assign state = state_q;

endmodule
